sisc_ifetch: RTL

//   Instruction fetch unit: the producer side of the SISC core's 32-bit ir input.

---
 rtl/sisc_pkg.sv | 17 +
 rtl/sisc_ifetch_if.sv | 54 +++++
 rtl/sisc_ifetch_buf.sv | 87 ++++++++
 rtl/sisc_ifetch.sv | 112 +++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// sisc_pkg
//   Shared definitions for the SISC instruction fetch slice: default bus
//   widths, the default reset program counter and the fetch FSM encoding.
package sisc_pkg;

  localparam int          ADDR_W_DEF   = 16;
  localparam int          DATA_W_DEF   = 32;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  // Fetch sequencer states: waiting to issue, request outstanding, dead cycle after ack
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sisc_ifetch_if.sv
// sisc_ifetch_if
//   Bundles every handshake of the fetch unit: the instruction memory
//   req/ack read port, the valid/ready instruction port towards the core and
//   the branch redirect input from the control unit.
//   master : the fetch unit (drives mem_req/mem_addr and ir/ir_valid/ir_pc)
//   slave  : the surroundings (memory, core, control unit)
interface sisc_ifetch_if
  import sisc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              fetch_en;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              ir_ready;
  logic [ADDR_W-1:0] ir_pc;
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;

  modport master (
    input  fetch_en,
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output ir,
    output ir_valid,
    input  ir_ready,
    output ir_pc,
    input  br_taken,
    input  br_addr
  );

  modport slave (
    output fetch_en,
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  ir,
    input  ir_valid,
    output ir_ready,
    input  ir_pc,
    output br_taken,
    output br_addr
  );

endinterface

// File: rtl/sisc_ifetch_buf.sv
// sisc_ifetch_buf
//   Two-entry FIFO of {pc, instruction word}. Entry 0 is always the head, so
//   the head registers keep their last contents when the FIFO drains.
//   clk, rst_f          : clock, asynchronous active-low reset
//   push, push_pc/word  : write a fetched word
//   pop                 : head consumed (only asserted while count != 0)
//   flush               : discard all entries; wins over push and pop
//   head_pc, head_word  : current head entry
//   count               : number of valid entries (0..2)
module sisc_ifetch_buf
  import sisc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_word,
  input  logic              pop,
  input  logic              flush,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_word,
  output logic [1:0]        count
);

  logic [ADDR_W-1:0] pc0, pc1;
  logic [DATA_W-1:0] w0, w1;
  logic [1:0]        cnt;

  // Shift-style FIFO: a pop moves entry 1 into entry 0; a flush only clears
  // the count so the head still shows the last word.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt <= 2'd0;
      pc0 <= '0;
      w0  <= '0;
      pc1 <= '0;
      w1  <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            pc0 <= push_pc;
            w0  <= push_word;
            cnt <= 2'd1;
          end else if (cnt == 2'd1) begin
            pc1 <= push_pc;
            w1  <= push_word;
            cnt <= 2'd2;
          end
        end
        2'b01: begin
          if (cnt == 2'd2) begin
            pc0 <= pc1;
            w0  <= w1;
          end
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            pc0 <= pc1;
            w0  <= w1;
            pc1 <= push_pc;
            w1  <= push_word;
          end else begin
            pc0 <= push_pc;
            w0  <= push_word;
            cnt <= 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_pc   = pc0;
  assign head_word = w0;
  assign count     = cnt;

endmodule

// File: rtl/sisc_ifetch.sv
// sisc_ifetch
//   Instruction fetch unit feeding the SISC core's ir input. Holds the program
//   counter, issues one word read at a time over req/ack, buffers up to two
//   words and hands them to the core over valid/ready. Branch redirects flush
//   the buffer and drop any word whose request predates the redirect.
//   clk   : system clock (rising edge)
//   rst_f : asynchronous active-low reset
//   bus   : sisc_ifetch_if master (memory port, instruction port, redirect)
module sisc_ifetch
  import sisc_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic           clk,
  input  logic           rst_f,
  sisc_ifetch_if.master  bus
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              discard;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;

  logic [1:0]        count;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_word;

  logic              acked;
  logic              push;
  logic              pop;
  logic              can_issue;
  logic [ADDR_W-1:0] target;

  // Only one request is ever outstanding, and none is outstanding outside
  // REQ, so the buffer count alone decides whether a new request fits.
  assign acked     = (state == ST_REQ) && bus.mem_ack;
  assign push      = acked && !discard && !bus.br_taken;
  assign pop       = bus.ir_valid && bus.ir_ready;
  assign can_issue = bus.fetch_en && (count < 2'd2);
  assign target    = bus.br_taken ? bus.br_addr : pc;

  // Fetch sequencer. GAP's single dead cycle also makes the IDLE issue
  // decision, giving back-to-back requests one idle cycle between them.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      discard <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          pc <= target;
          if (can_issue) begin
            state  <= ST_REQ;
            req_q  <= 1'b1;
            addr_q <= target;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus.mem_ack) begin
            state   <= ST_GAP;
            req_q   <= 1'b0;
            discard <= 1'b0;
            // A discarded request already had pc moved to the redirect target
            if (bus.br_taken) begin
              pc <= bus.br_addr;
            end else if (!discard) begin
              pc <= pc + ADDR_W'(1);
            end
          end else if (bus.br_taken) begin
            discard <= 1'b1;
            pc      <= bus.br_addr;
          end
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  sisc_ifetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst_f     (rst_f),
    .push      (push),
    .push_pc   (addr_q),
    .push_word (bus.mem_rdata),
    .pop       (pop),
    .flush     (bus.br_taken),
    .head_pc   (head_pc),
    .head_word (head_word),
    .count     (count)
  );

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;
  assign bus.ir       = head_word;
  assign bus.ir_pc    = head_pc;
  assign bus.ir_valid = (count != 2'd0);

endmodule
